adc_frame_align: RTL and testbench
==================================

ADC_FRAME_ALIGN -- requirements
Module: adc_frame_align

Interface
REQ-001 Parameter FRM_PATTERN, default 14'h3F80: expected deserialized frame-lane word (7 ones, 7 zeros).
REQ-002 Parameter SETTLE_CYC, default 4: wait cycles after reset, start or bitslip before comparing; legal range 2..15.
REQ-003 Parameter MATCH_CNT, default 8: consecutive matching words required to declare lock; legal range 1..15.
REQ-004 Parameter LOSS_CNT, default 4: consecutive mismatching words in lock that declare loss; legal range 1..15.
REQ-005 FrmClkDiv  input  1  sole clock, the divided deserializer clock; all logic on its rising edge.
REQ-006 FrmRstN  input  1  reset, asynchronous assert, active-low.
REQ-007 FrmData  input  14  parallel word from the frame-lane 1x14 DDR deserializer, new word every cycle.
REQ-008 FrmAlignStart  input  1  synchronous restart request, sampled each cycle.
REQ-009 FrmBitslip  output  1  single-cycle slip pulse, drives frame and both data-lane deserializers.
REQ-010 FrmAlignDone  output  1  frame aligned; consumed by the data-lane stage as its alignment-done input.
REQ-011 FrmAlignErr  output  1  all 14 bit phases tried without lock.
REQ-012 FrmSlipCnt  output  4  slips issued since last reset or start.

Function
REQ-013 FSM states SHALL be SETTLE, CHECK, SLIP, LOCKED, ERROR; all outputs registered, no combinational input-to-output path.
REQ-014 SETTLE: SettleCnt increments each cycle; at SettleCnt == SETTLE_CYC-1 go to CHECK with MatchCnt cleared.
REQ-015 CHECK, FrmData == FRM_PATTERN: MatchCnt increments; at MatchCnt == MATCH_CNT-1 go to LOCKED.
REQ-016 CHECK, mismatch: FrmSlipCnt < 13 -> SLIP; FrmSlipCnt == 13 -> ERROR; MatchCnt cleared either way.
REQ-017 SLIP lasts exactly one cycle: FrmBitslip = 1 during it, FrmSlipCnt increments, then SETTLE with SettleCnt cleared.
REQ-018 FrmBitslip SHALL never be high two consecutive cycles; minimum spacing between pulses is SETTLE_CYC+2 cycles.
REQ-019 LOCKED: FrmAlignDone = 1; FrmSlipCnt frozen.
REQ-020 ERROR: FrmAlignErr = 1, FrmAlignDone = 0, no further slips; exit only via FrmAlignStart or reset.
REQ-021 FrmAlignStart = 1 in any state: next state SETTLE, SettleCnt, MatchCnt, LossCnt and FrmSlipCnt cleared, FrmAlignDone, FrmAlignErr and FrmBitslip 0 after that edge; start has priority over every other transition.
REQ-022 FrmAlignStart held high keeps the block in SETTLE; alignment begins on the first cycle it is low.
REQ-023 Counters SHALL never wrap; each is cleared on the transition that consumes it.

Reset
REQ-024 FrmRstN low SHALL immediately force state SETTLE, all counters 0, FrmBitslip 0, FrmAlignDone 0, FrmAlignErr 0, FrmSlipCnt 0, including mid-SLIP.
REQ-025 Deassertion is expected synchronized externally to FrmClkDiv; first SETTLE cycle is the first rising edge after release.

Configuration
REQ-026 Macro ADC_FRAME_ALIGN_LOSS_MON_EN defined: in LOCKED, each mismatching word increments LossCnt, each matching word clears it; at LossCnt == LOSS_CNT-1 with a further mismatch, go to SETTLE, FrmAlignDone drops, FrmSlipCnt cleared.
REQ-027 Macro not defined: LossCnt absent, LOCKED is sticky until FrmAlignStart or reset; FrmData ignored in LOCKED.

Verification
REQ-028 Defaults, FrmData = 14'h3F80 constant from reset release -> no FrmBitslip, FrmAlignDone high after 12th rising edge, FrmSlipCnt = 0.
REQ-029 Word correct only after 3 slips (bench rotates model on each pulse) -> 3 pulses 6 cycles apart, FrmAlignDone high after edge 30, FrmSlipCnt = 3.
REQ-030 FrmData = 14'h0000 constant -> 13 pulses, then FrmAlignErr = 1, FrmSlipCnt = 13, no further pulses over 100 cycles; FrmAlignStart pulse clears FrmAlignErr next edge.
REQ-031 Macro defined, locked, 3 mismatches then match -> FrmAlignDone stays 1; 4 consecutive mismatches -> FrmAlignDone 0 after 4th, realignment restarts with FrmSlipCnt = 0.
REQ-032 Macro undefined, locked, 20 mismatches -> FrmAlignDone stays 1, no FrmBitslip.
REQ-033 FrmRstN asserted during SLIP cycle -> FrmBitslip 0 without waiting for a clock edge; FrmAlignStart during SETTLE after 2 slips -> FrmSlipCnt 0 next edge.

Source files
------------

// File: rtl/adc_frame_align.sv
// Frame-lane word aligner: searches the 14 bit phases of the frame deserializer with bitslip pulses.
// Define ADC_FRAME_ALIGN_LOSS_MON_EN to enable loss-of-lock detection while LOCKED.
module adc_frame_align #(
  parameter logic [13:0] FRM_PATTERN = 14'h3F80,
  parameter int          SETTLE_CYC  = 4,
  parameter int          MATCH_CNT   = 8,
  parameter int          LOSS_CNT    = 4
) (
  input  logic        FrmClkDiv,
  input  logic        FrmRstN,
  input  logic [13:0] FrmData,
  input  logic        FrmAlignStart,
  output logic        FrmBitslip,
  output logic        FrmAlignDone,
  output logic        FrmAlignErr,
  output logic [3:0]  FrmSlipCnt
);

  if (SETTLE_CYC < 2 || SETTLE_CYC > 15) begin : g_bad_settle_cyc
    $error("SETTLE_CYC out of range 2..15");
  end
  if (MATCH_CNT < 1 || MATCH_CNT > 15) begin : g_bad_match_cnt
    $error("MATCH_CNT out of range 1..15");
  end
  if (LOSS_CNT < 1 || LOSS_CNT > 15) begin : g_bad_loss_cnt
    $error("LOSS_CNT out of range 1..15");
  end

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] MATCH_LAST  = 4'(MATCH_CNT - 1);
  localparam logic [3:0] SLIP_LAST   = 4'd13;

  typedef enum logic [2:0] {
    S_SETTLE,
    S_CHECK,
    S_SLIP,
    S_LOCKED,
    S_ERROR
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [3:0] match_cnt_q, match_cnt_d;
  logic [3:0] slip_cnt_q, slip_cnt_d;
  logic       bitslip_q, done_q, err_q;
  logic       word_match;

`ifdef ADC_FRAME_ALIGN_LOSS_MON_EN
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_CNT - 1);
  logic [3:0] loss_cnt_q, loss_cnt_d;
`endif

  assign word_match = (FrmData == FRM_PATTERN);

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    match_cnt_d  = match_cnt_q;
    slip_cnt_d   = slip_cnt_q;
`ifdef ADC_FRAME_ALIGN_LOSS_MON_EN
    loss_cnt_d   = loss_cnt_q;
`endif
    if (FrmAlignStart) begin
      state_d      = S_SETTLE;
      settle_cnt_d = 4'd0;
      match_cnt_d  = 4'd0;
      slip_cnt_d   = 4'd0;
`ifdef ADC_FRAME_ALIGN_LOSS_MON_EN
      loss_cnt_d   = 4'd0;
`endif
    end else begin
      unique case (state_q)
        S_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d      = S_CHECK;
            settle_cnt_d = 4'd0;
            match_cnt_d  = 4'd0;
          end else begin
            settle_cnt_d = settle_cnt_q + 4'd1;
          end
        end
        S_CHECK: begin
          if (word_match) begin
            if (match_cnt_q == MATCH_LAST) begin
              state_d     = S_LOCKED;
              match_cnt_d = 4'd0;
            end else begin
              match_cnt_d = match_cnt_q + 4'd1;
            end
          end else begin
            match_cnt_d = 4'd0;
            // Thirteen slips already tried means all 14 phases failed.
            if (slip_cnt_q == SLIP_LAST) begin
              state_d = S_ERROR;
            end else begin
              state_d    = S_SLIP;
              slip_cnt_d = slip_cnt_q + 4'd1;
            end
          end
        end
        S_SLIP: begin
          state_d      = S_SETTLE;
          settle_cnt_d = 4'd0;
        end
        S_LOCKED: begin
`ifdef ADC_FRAME_ALIGN_LOSS_MON_EN
          if (!word_match) begin
            if (loss_cnt_q == LOSS_LAST) begin
              state_d      = S_SETTLE;
              settle_cnt_d = 4'd0;
              slip_cnt_d   = 4'd0;
              loss_cnt_d   = 4'd0;
            end else begin
              loss_cnt_d = loss_cnt_q + 4'd1;
            end
          end else begin
            loss_cnt_d = 4'd0;
          end
`endif
        end
        S_ERROR: begin
          state_d = S_ERROR;
        end
        default: begin
          state_d = S_SETTLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge FrmClkDiv or negedge FrmRstN) begin
    if (!FrmRstN) begin
      state_q      <= S_SETTLE;
      settle_cnt_q <= 4'd0;
      match_cnt_q  <= 4'd0;
      slip_cnt_q   <= 4'd0;
      bitslip_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      match_cnt_q  <= match_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      bitslip_q    <= (state_d == S_SLIP);
      done_q       <= (state_d == S_LOCKED);
      err_q        <= (state_d == S_ERROR);
    end
  end

`ifdef ADC_FRAME_ALIGN_LOSS_MON_EN
  always_ff @(posedge FrmClkDiv or negedge FrmRstN) begin
    if (!FrmRstN) begin
      loss_cnt_q <= 4'd0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end
`endif

  assign FrmBitslip   = bitslip_q;
  assign FrmAlignDone = done_q;
  assign FrmAlignErr  = err_q;
  assign FrmSlipCnt   = slip_cnt_q;

endmodule

// File: tb/tb_adc_frame_align.sv
// Randomized scoreboard bench for adc_frame_align; the frame lane is modelled as a rotated
// pattern whose phase advances on every predicted slip.
module tb_adc_frame_align;

  localparam logic [13:0] PAT    = 14'h3F80;
  localparam int          SETTLE = 4;
  localparam int          MATCHN = 8;
  localparam int          LOSSN  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] data = 14'h0;
  logic        start = 1'b0;
  logic        bitslip, done, err;
  logic [3:0]  slipcnt;

  always #5 clk = ~clk;

  adc_frame_align dut (
    .FrmClkDiv    (clk),
    .FrmRstN      (rst_n),
    .FrmData      (data),
    .FrmAlignStart(start),
    .FrmBitslip   (bitslip),
    .FrmAlignDone (done),
    .FrmAlignErr  (err),
    .FrmSlipCnt   (slipcnt)
  );

  typedef struct packed {
    logic       bs;
    logic       dn;
    logic       er;
    logic [3:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference: an alignment attempt is SETTLE waiting cycles followed by a window of word checks.
  int m_age, m_run, m_slips, m_loss;
  bit m_pulse, m_locked, m_failed;
  int offset;
  bit zero_mode;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [13:0] rotl(input logic [13:0] x, input int k);
    logic [27:0] d;
    d = {x, x} << k;
    return d[27:14];
  endfunction

  function automatic void model_reset();
    m_age = 0; m_run = 0; m_slips = 0; m_loss = 0;
    m_pulse = 0; m_locked = 0; m_failed = 0;
  endfunction

  // Advances the model by one clock edge; returns 1 when a new slip pulse begins.
  function automatic bit model_step(input bit st, input logic [13:0] w);
    bit fired = 0;
    if (st) begin
      model_reset();
    end else if (m_failed) begin
      m_failed = 1;
    end else if (m_pulse) begin
      m_pulse = 0; m_age = 0; m_run = 0;
    end else if (m_locked) begin
`ifdef ADC_FRAME_ALIGN_LOSS_MON_EN
      if (w != PAT) begin
        m_loss++;
        if (m_loss == LOSSN) begin
          m_locked = 0; m_slips = 0; m_loss = 0; m_age = 0; m_run = 0;
        end
      end else begin
        m_loss = 0;
      end
`endif
    end else if (m_age < SETTLE) begin
      m_age++;
    end else if (w == PAT) begin
      m_run++;
      if (m_run == MATCHN) m_locked = 1;
    end else begin
      m_run = 0;
      if (m_slips == 13) m_failed = 1;
      else begin
        m_slips++; m_pulse = 1; fired = 1;
      end
    end
    return fired;
  endfunction

  // Drive one word at a falling edge, predict the next rising edge, then move to the next falling edge.
  task automatic cycle(input bit st, input bit corrupt);
    logic [13:0] w;
    if (zero_mode) w = 14'h0;
    else if (corrupt) begin
      w = 14'($urandom);
      if (w == PAT) w = ~PAT;
    end else w = rotl(PAT, offset);
    data  = w;
    start = st;
    if (model_step(st, w)) offset = (offset + 13) % 14;
    exp_q.push_back(exp_t'{m_pulse, m_locked, m_failed, 4'(m_slips)});
    @(negedge clk);
  endtask

  task automatic run(input int n, input int corrupt_pct);
    for (int i = 0; i < n; i++)
      cycle(1'b0, ($urandom_range(99) < corrupt_pct));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bitslip", bitslip, e.bs);
        check("align_done", done, e.dn);
        check("align_err", err, e.er);
        check("slip_cnt", slipcnt, e.sc);
      end
    end
  end

  initial begin : stim
    model_reset();
    offset = 0;
    zero_mode = 0;
    data = PAT;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bitslip", bitslip, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_slipcnt", slipcnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned from reset release: lock after the 12th edge, no slips.
    run(20, 0);

    // Three slips needed.
    offset = 3;
    cycle(1'b1, 1'b0);
    run(40, 0);

    // No valid phase: 13 slips then error, then silence, then start clears it.
    zero_mode = 1;
    cycle(1'b1, 1'b0);
    run(14 * 6 + 10 + 100, 0);
    cycle(1'b1, 1'b0);
    run(10, 0);
    zero_mode = 0;

    // Worst case phase: 13 slips and a lock on the last phase.
    offset = 13;
    cycle(1'b1, 1'b0);
    run(100, 0);

    // Lock, then disturb the locked word.
    offset = 0;
    cycle(1'b1, 1'b0);
    run(15, 0);
`ifdef ADC_FRAME_ALIGN_LOSS_MON_EN
    run(3, 100);
    run(1, 0);
    run(4, 100);
    run(20, 0);
`else
    run(20, 100);
    run(5, 0);
`endif

    // Start held high keeps the block waiting.
    offset = $urandom_range(13);
    repeat (5) cycle(1'b1, 1'b0);
    run(100, 0);

    // Start after two slips, while settling.
    offset = 5;
    cycle(1'b1, 1'b0);
    run(13, 0);
    cycle(1'b1, 1'b0);
    run(50, 0);

    // Random phases with occasional corrupted words.
    for (int k = 0; k < 8; k++) begin
      offset = $urandom_range(13);
      cycle(1'b1, 1'b0);
      run(120, 4);
    end

    // Reset asserted in the middle of a slip pulse.
    offset = 2;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 20 && !m_pulse; i++) cycle(1'b0, 1'b0);
    check("slip_before_reset", bitslip, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_bitslip", bitslip, 0);
    check("async_rst_slipcnt", slipcnt, 0);
    check("async_rst_done", done, 0);
    check("async_rst_err", err, 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    offset = 0;
    rst_n = 1'b1;
    run(20, 0);

    @(posedge clk);
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
